// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the matrix-multiplier control blocks.
// Contents:
//   disp_state_t  - dispatcher FSM states (IDLE, RUN, DONE)
//   NUM_CORES_DEF - default number of compute cores
//   ROWS_DEF      - default maximum result rows per job
//   TIMEOUT_DEF   - default per-row watchdog limit in cycles
package matmul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } disp_state_t;

  localparam int NUM_CORES_DEF = 4;
  localparam int ROWS_DEF      = 8;
  localparam int TIMEOUT_DEF   = 1024;

endpackage

// File: rtl/lowest_idle_sel.sv
// Combinational priority encoder: picks the lowest-indexed core whose busy
// bit is clear.
// Ports:
//   busy  in  N  per-core busy bitmap
//   grant out N  one-hot select of the lowest idle core (all zero if none)
//   valid out 1  at least one core is idle
module lowest_idle_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] busy,
  output logic [N-1:0] grant,
  output logic         valid
);

  // free_below[i] is set when some core with index < i is idle, which
  // blocks core i from being granted.
  logic [N:0] free_below;

  assign free_below[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_pri
    assign grant[gi]        = ~busy[gi] & ~free_below[gi];
    assign free_below[gi+1] = free_below[gi] | ~busy[gi];
  end

  assign valid = free_below[N];

endmodule

// File: rtl/n_core_dispatcher.sv
// Row dispatcher for an N-core matrix multiplier. A job is requested with
// the status level; each result row is handed to the lowest-indexed idle
// core, completions are counted, and end_process is raised once all rows
// of the job have finished. end_process is held until status drops.
//
// Optional feature macro: CORE_TIMEOUT_EN
//   Defined   - per-core watchdog; a core busy for TIMEOUT_CYCLES without
//               core_done raises error and ends the job.
//   Undefined - no watchdog; error is constant 0.
//
// Ports:
//   clk          in   1                 clock, rising edge
//   rst          in   1                 synchronous active-high reset
//   status       in   1                 job request level (sampled in IDLE)
//   num_rows     in   ROW_W+1           rows in the job (clamped to ROWS)
//   core_start   out  NUM_CORES         one-cycle start pulse per core
//   core_row     out  NUM_CORES*ROW_W   row index for core i in slice i
//   core_done    in   NUM_CORES         one-cycle completion pulse per core
//   busy         out  1                 job running
//   rows_done    out  ROW_W+1           completed rows in the current job
//   end_process  out  1                 job finished
//   error        out  1                 watchdog fired
module n_core_dispatcher
  import matmul_ctrl_pkg::*;
#(
  parameter int NUM_CORES      = NUM_CORES_DEF,
  parameter int ROWS           = ROWS_DEF,
  parameter int ROW_W          = $clog2(ROWS),
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       status,
  input  logic [ROW_W:0]             num_rows,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*ROW_W-1:0] core_row,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic                       busy,
  output logic [ROW_W:0]             rows_done,
  output logic                       end_process,
  output logic                       error
);

  localparam int CNT_W = ROW_W + 1;

  if (NUM_CORES < 1 || NUM_CORES > 16 || ROWS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("n_core_dispatcher: parameter out of range");
  end

  disp_state_t state_reg, state_next;

  logic [CNT_W-1:0]           count_reg, count_next;
  logic [CNT_W-1:0]           next_row_reg, next_row_next;
  logic [CNT_W-1:0]           rows_done_reg, rows_done_next;
  logic [NUM_CORES-1:0]       busy_map_reg, busy_map_next;
  logic [NUM_CORES-1:0]       core_start_reg, core_start_next;
  logic [NUM_CORES*ROW_W-1:0] core_row_reg, core_row_next;
  logic                       busy_reg;
  logic                       end_reg;
  logic                       error_reg, error_next;

  logic [CNT_W-1:0]     num_rows_clamped;
  logic [NUM_CORES-1:0] valid_done;
  logic [CNT_W-1:0]     done_cnt;
  logic [CNT_W-1:0]     rows_done_sum;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic                 dispatch_ok;
  logic                 timeout_hit;

  assign num_rows_clamped = (num_rows > CNT_W'(ROWS)) ? CNT_W'(ROWS) : num_rows;

  // Completions from cores that were never started (or were cleared by
  // reset/timeout) are dropped here.
  assign valid_done = core_done & busy_map_reg;

  // The count of valid dones is bounded by the rows still outstanding, so
  // CNT_W bits are always enough.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + CNT_W'(valid_done[i]);
    end
  end

  assign rows_done_sum = rows_done_reg + done_cnt;

  // Selection uses the registered bitmap, so a core finishing this cycle
  // is only eligible for a new row from the next cycle on.
  lowest_idle_sel #(
    .N (NUM_CORES)
  ) u_sel (
    .busy  (busy_map_reg),
    .grant (grant),
    .valid (grant_valid)
  );

  assign dispatch_ok = (state_reg == RUN) && grant_valid &&
                       (next_row_reg < count_reg) && !timeout_hit;

`ifdef CORE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_CORES-1:0] expire;

  // A counter restarts when its core is dispatched and advances every
  // cycle the core stays busy. It expires on the edge at which it would
  // reach TIMEOUT_CYCLES with no done arriving in the same cycle.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_wdog
    logic [TMO_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        tmo_cnt_reg <= '0;
      end else if (core_start_next[gi]) begin
        tmo_cnt_reg <= '0;
      end else if (busy_map_reg[gi]) begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end
    end

    assign expire[gi] = busy_map_reg[gi] & ~core_done[gi] &
                        (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  assign timeout_hit = (state_reg == RUN) && (|expire);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    next_row_next   = next_row_reg;
    rows_done_next  = rows_done_reg;
    busy_map_next   = busy_map_reg;
    core_start_next = '0;
    core_row_next   = core_row_reg;
    error_next      = error_reg;

    unique case (state_reg)
      IDLE: begin
        if (status) begin
          count_next     = num_rows_clamped;
          next_row_next  = '0;
          rows_done_next = '0;
          busy_map_next  = '0;
          error_next     = 1'b0;
          state_next     = (num_rows_clamped == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        rows_done_next = rows_done_sum;
        busy_map_next  = busy_map_reg & ~valid_done;
        if (timeout_hit) begin
          busy_map_next = '0;
          error_next    = 1'b1;
          state_next    = DONE;
        end else begin
          if (dispatch_ok) begin
            busy_map_next   = busy_map_next | grant;
            core_start_next = grant;
            next_row_next   = next_row_reg + CNT_W'(1);
            for (int i = 0; i < NUM_CORES; i++) begin
              if (grant[i]) begin
                core_row_next[i*ROW_W +: ROW_W] = next_row_reg[ROW_W-1:0];
              end
            end
          end
          if (rows_done_sum == count_reg) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (!status) begin
          error_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      next_row_reg   <= '0;
      rows_done_reg  <= '0;
      busy_map_reg   <= '0;
      core_start_reg <= '0;
      core_row_reg   <= '0;
      busy_reg       <= 1'b0;
      end_reg        <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      count_reg      <= count_next;
      next_row_reg   <= next_row_next;
      rows_done_reg  <= rows_done_next;
      busy_map_reg   <= busy_map_next;
      core_start_reg <= core_start_next;
      core_row_reg   <= core_row_next;
      busy_reg       <= (state_next == RUN);
      end_reg        <= (state_next == DONE);
      error_reg      <= error_next;
    end
  end

  assign core_start  = core_start_reg;
  assign core_row    = core_row_reg;
  assign busy        = busy_reg;
  assign rows_done   = rows_done_reg;
  assign end_process = end_reg;
  assign error       = error_reg;

endmodule
